mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Serial-command memory responder: 2-bit symbol stream in, memory strobes out, read replies serialised back.
// Optional feature: define REPLY_DELAY_EN to insert REPLY_DELAY idle cycles between capture and reply.
`timescale 1ns/1ps
module mem_responder #(
  parameter int NSHIFT      = 2,
  parameter int REPLY_DELAY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  rx_pins,
  output logic [1:0]  tx_pins,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_wmask,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        protocol_error
);

  if (NSHIFT != 2) begin : g_bad_nshift
    $error("mem_responder: only NSHIFT=2 is supported");
  end
  if (REPLY_DELAY < 0 || REPLY_DELAY > 15) begin : g_bad_delay
    $error("mem_responder: REPLY_DELAY must fit the 4-bit delay counter");
  end

  localparam logic [2:0] LAST16 = 3'(16 / NSHIFT - 1);
  localparam logic [2:0] LAST8  = 3'(8 / NSHIFT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HEADER, S_ADDR, S_WDATA, S_MEM_WRITE, S_MEM_READ, S_CAPTURE,
`ifdef REPLY_DELAY_EN
    S_DELAY,
`endif
    S_REPLY_START, S_REPLY_DATA
  } state_e;

  typedef enum logic [1:0] {
    CMD_READ16  = 2'd0,
    CMD_WRITE8  = 2'd1,
    CMD_WRITE16 = 2'd2,
    CMD_BAD     = 2'd3
  } cmd_e;

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] reply_q, reply_d;
`ifdef REPLY_DELAY_EN
  localparam logic [3:0] DLY_LOAD = 4'(REPLY_DELAY - 1);
  logic [3:0]  dly_q, dly_d;
`endif

  logic [1:0] tx;
  logic       we, re, perr;
  logic [2:0] wdata_last;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    reply_d    = reply_q;
`ifdef REPLY_DELAY_EN
    dly_d      = dly_q;
`endif
    tx         = 2'b00;
    we         = 1'b0;
    re         = 1'b0;
    perr       = 1'b0;
    wdata_last = (cmd_q == CMD_WRITE8) ? LAST8 : LAST16;

    unique case (state_q)
      S_IDLE: begin
        if (rx_pins == 2'b01) state_d = S_HEADER;
        else if (rx_pins != 2'b00) perr = 1'b1;
      end
      S_HEADER: begin
        if (cmd_e'(rx_pins) == CMD_BAD) begin
          perr    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cmd_d   = cmd_e'(rx_pins);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        addr_d = {rx_pins, addr_q[15:2]};
        if (cnt_q == LAST16) state_d = (cmd_q == CMD_READ16) ? S_MEM_READ : S_WDATA;
        else                 cnt_d   = cnt_q + 3'd1;
      end
      S_WDATA: begin
        // Byte writes shift only the low byte and keep the upper byte zero.
        if (cmd_q == CMD_WRITE8) wdata_d = {8'h00, rx_pins, wdata_q[7:2]};
        else                     wdata_d = {rx_pins, wdata_q[15:2]};
        if (cnt_q == wdata_last) state_d = S_MEM_WRITE;
        else                     cnt_d   = cnt_q + 3'd1;
      end
      S_MEM_WRITE: begin
        we      = 1'b1;
        state_d = S_IDLE;
      end
      S_MEM_READ: begin
        re      = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        reply_d = mem_rdata;
`ifdef REPLY_DELAY_EN
        if (REPLY_DELAY == 0) begin
          state_d = S_REPLY_START;
        end else begin
          dly_d   = DLY_LOAD;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (dly_q == 4'd0) state_d = S_REPLY_START;
        else               dly_d   = dly_q - 4'd1;
`else
        state_d = S_REPLY_START;
`endif
      end
      S_REPLY_START: begin
        tx      = 2'b01;
        state_d = S_REPLY_DATA;
      end
      S_REPLY_DATA: begin
        tx      = reply_q[1:0];
        reply_d = {2'b00, reply_q[15:2]};
        if (cnt_q == LAST16) state_d = S_IDLE;
        else                 cnt_d   = cnt_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Symbols arriving while the responder is not listening are flagged and dropped.
    if (!(state_q inside {S_IDLE, S_HEADER, S_ADDR, S_WDATA}) && rx_pins != 2'b00) perr = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_READ16;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      reply_q <= '0;
`ifdef REPLY_DELAY_EN
      dly_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      reply_q <= reply_d;
`ifdef REPLY_DELAY_EN
      dly_q   <= dly_d;
`endif
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not just after it.
  assign tx_pins        = reset ? 2'b00 : tx;
  assign mem_we         = !reset && we;
  assign mem_re         = !reset && re;
  assign mem_wmask      = (!reset && we) ? ((cmd_q == CMD_WRITE8) ? 2'b01 : 2'b11) : 2'b00;
  assign mem_addr       = reset ? 16'h0000 : addr_q;
  assign mem_wdata      = reset ? 16'h0000 : wdata_q;
  assign busy           = !reset && (state_q != S_IDLE);
  assign protocol_error = !reset && perr;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of read/write transactions run back to back,
// plus hand sequences for bad header, idle garbage, mid-message reset and ignored-symbol injection.
`timescale 1ns/1ps
module tb_mem_responder;

`ifdef REPLY_DELAY_EN
  localparam int DLY = 3;
`else
  localparam int DLY = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rx_pins;
  logic [1:0]  tx_pins;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wmask;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        protocol_error;

  int n_vec = 0;
  int n_err = 0;

  mem_responder #(.NSHIFT(2), .REPLY_DELAY(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_pins        (rx_pins),
    .tx_pins        (tx_pins),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .protocol_error (protocol_error)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] rdata;
    int          strobe_cyc;
    logic [15:0] exp_wdata;
    logic [1:0]  exp_wmask;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs cycles 0..n_run-1 of a transaction; inject_cyc drives a stray start symbol.
  task automatic run_txn(input int idx, input vec_t v, input int inject_cyc, input int n_run);
    int          n;
    logic [1:0]  exp_tx;
    logic        exp_perr;
    logic        is_read;
    logic [5:0]  act_f, exp_f;
    is_read = (v.cmd == 2'd0);
    n = is_read ? 21 + DLY : v.strobe_cyc + 1;
    if (n_run < n) n = n_run;
    for (int c = 0; c < n; c++) begin
      if (c == 0)                                   rx_pins = 2'b01;
      else if (c == 1)                              rx_pins = v.cmd;
      else if (c <= 9)                              rx_pins = 2'((v.addr >> (2 * (c - 2))) & 16'h3);
      else if (!is_read && c < v.strobe_cyc)        rx_pins = 2'((v.data >> (2 * (c - 10))) & 16'h3);
      else                                          rx_pins = 2'b00;
      exp_perr = 1'b0;
      if (c == inject_cyc) begin
        rx_pins  = 2'b01;
        exp_perr = 1'b1;
      end
      mem_rdata = (c == 11) ? v.rdata : 16'hDEAD;
      exp_tx = 2'b00;
      if (is_read && c == 12 + DLY) exp_tx = 2'b01;
      else if (is_read && c >= 13 + DLY) exp_tx = 2'((v.rdata >> (2 * (c - 13 - DLY))) & 16'h3);
      @(negedge clk);
      act_f = {busy, mem_re, mem_we, protocol_error, tx_pins};
      exp_f = {c != 0, is_read && c == v.strobe_cyc, !is_read && c == v.strobe_cyc, exp_perr, exp_tx};
      check($sformatf("v%0d c%0d {busy,re,we,perr,tx}", idx, c), 64'(act_f), 64'(exp_f));
      if (c == v.strobe_cyc) begin
        check($sformatf("v%0d mem_addr", idx), 64'(mem_addr), 64'(v.addr));
        if (!is_read)
          check($sformatf("v%0d {wdata,wmask}", idx), 64'({mem_wdata, mem_wmask}),
                64'({v.exp_wdata, v.exp_wmask}));
      end
      next_cycle();
    end
    rx_pins = 2'b00;
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    check(name, {24'h0, tx_pins, mem_we, mem_re, mem_wmask, mem_addr, mem_wdata, busy, protocol_error}, 64'h0);
  endtask

  initial begin
    //          cmd    addr      data      rdata     strobe wdata     wmask
    vecs[0] = '{2'd0, 16'h1234, 16'h0000, 16'hBEEF, 10,   16'h0000, 2'b00};
    vecs[1] = '{2'd2, 16'h00FF, 16'hA55A, 16'h0000, 18,   16'hA55A, 2'b11};
    vecs[2] = '{2'd1, 16'h8001, 16'h007E, 16'h0000, 14,   16'h007E, 2'b01};
    vecs[3] = '{2'd0, 16'hFFFF, 16'h0000, 16'h0001, 10,   16'h0000, 2'b00};
    vecs[4] = '{2'd2, 16'h0000, 16'hFFFF, 16'h0000, 18,   16'hFFFF, 2'b11};
    vecs[5] = '{2'd0, 16'hA5C3, 16'h0000, 16'h8000, 10,   16'h0000, 2'b00};

    reset     = 1'b1;
    rx_pins   = 2'b01;
    mem_rdata = 16'h0000;
    next_cycle();
    check_quiet("outputs during reset");
    next_cycle();
    reset   = 1'b0;
    rx_pins = 2'b00;
    check_quiet("outputs after reset");
    next_cycle();

    // Header 3 is rejected, then a normal read follows.
    rx_pins = 2'b01;
    @(negedge clk);
    check("hdr3 c0 {busy,perr}", 64'({busy, protocol_error}), 64'(2'b00));
    next_cycle();
    rx_pins = 2'b11;
    @(negedge clk);
    check("hdr3 c1 {busy,perr}", 64'({busy, protocol_error}), 64'(2'b11));
    next_cycle();
    rx_pins = 2'b00;
    @(negedge clk);
    check("hdr3 c2 {busy,perr}", 64'({busy, protocol_error}), 64'(2'b00));
    next_cycle();
    run_txn(100, vecs[0], -1, 1000);

    // Non-start symbols in IDLE pulse an error and leave the responder idle.
    rx_pins = 2'b10;
    @(negedge clk);
    check("idle 10 {busy,perr}", 64'({busy, protocol_error}), 64'(2'b01));
    next_cycle();
    rx_pins = 2'b11;
    @(negedge clk);
    check("idle 11 {busy,perr}", 64'({busy, protocol_error}), 64'(2'b01));
    next_cycle();
    rx_pins = 2'b00;
    @(negedge clk);
    check("idle after junk busy", 64'(busy), 64'(0));
    next_cycle();

    // Table transactions run back to back with no gap cycles.
    for (int i = 0; i < 6; i++) run_txn(i, vecs[i], -1, 1000);

    // Stray start symbol during the reply is flagged; reply continues unchanged.
    run_txn(200, vecs[5], 13, 1000);

    // Reset at cycle 15 of a read.
    run_txn(300, vecs[0], -1, 15);
    reset = 1'b1;
    check_quiet("mid-read reset cycle 15");
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("post-reset cycle 16 {addr,busy,tx}", 64'({mem_addr, busy, tx_pins}), 64'h0);
    next_cycle();
    for (int c = 17; c < 27; c++) begin
      @(negedge clk);
      check($sformatf("post-reset c%0d {busy,re,we,perr,tx}", c),
            64'({busy, mem_re, mem_we, protocol_error, tx_pins}), 64'h0);
      next_cycle();
    end
    run_txn(400, vecs[2], -1, 1000);
    run_txn(401, vecs[3], -1, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
